// File: rtl/neighbor_scan_ctrl.sv
// rtl/neighbor_scan_ctrl.sv - fetches the neighbor table from byte memory and streams it to the best-neighbor datapath
module neighbor_scan_ctrl #(
    parameter logic [10:0] BASE_ADDR     = 11'h000,
    parameter int          MAX_NEIGHBORS = 32
) (
    input  logic        clock,
    input  logic        nrst,
    input  logic        en,
    input  logic        start,
    output logic        mem_rd,
    output logic [10:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic        dp_start,
    output logic [15:0] dp_word,
    output logic        dp_valid,
    output logic [1:0]  dp_sel,
    input  logic        dp_done,
    output logic        busy,
    output logic        done,
    output logic [15:0] scanned,
    output logic        clamp_err
);

    typedef enum logic [3:0] {
        IDLE, CNT_HI, CNT_LO, CNT_CAP, PRIME, RD_HI, RD_LO, CAP, WAIT_DP, FIN
    } state_t;

    localparam logic [15:0] MAX_N = 16'(MAX_NEIGHBORS);

    state_t      state, state_n;
    logic [7:0]  hi_byte;
    logic [10:0] word_addr, word_addr_n;
    logic [15:0] entry_idx, entry_n;
    logic [15:0] num_entries, num_n;
    logic [1:0]  word_idx, word_idx_n;
    logic        done_seen;

    logic        rd_r, start_r, valid_r, done_r, busy_r, clamp_r;
    logic [10:0] addr_r;
    logic [15:0] word_r, scanned_r;
    logic [1:0]  sel_r;

    logic        rd_n, start_n, valid_n, done_n, busy_n, clamp_n;
    logic [10:0] addr_n;
    logic [15:0] word_n, scanned_n;
    logic [1:0]  sel_n;

    logic [15:0] count_word, count_eff;
    logic        clamp_hit, last_word;

    assign count_word = {hi_byte, mem_data};
    assign clamp_hit  = count_word > MAX_N;
    assign count_eff  = clamp_hit ? MAX_N : count_word;
    assign last_word  = (word_idx == 2'd2) && (entry_idx + 16'd1 == num_entries);

    always_comb begin
        state_n     = state;
        word_addr_n = word_addr;
        entry_n     = entry_idx;
        word_idx_n  = word_idx;
        num_n       = num_entries;
        valid_n     = 1'b0;
        word_n      = word_r;
        sel_n       = sel_r;
        scanned_n   = scanned_r;
        clamp_n     = clamp_r;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n     = CNT_HI;
                    scanned_n   = '0;
                    clamp_n     = 1'b0;
                    word_addr_n = BASE_ADDR + 11'd2;
                    entry_n     = '0;
                    word_idx_n  = '0;
                end
            end
            CNT_HI:  state_n = CNT_LO;
            CNT_LO:  state_n = CNT_CAP;
            CNT_CAP: begin
                num_n   = count_eff;
                clamp_n = clamp_hit;
                state_n = (count_eff == 16'd0) ? FIN : PRIME;
            end
            PRIME:   state_n = RD_HI;
            RD_HI:   state_n = RD_LO;
            RD_LO:   state_n = CAP;
            CAP: begin
                valid_n     = 1'b1;
                word_n      = {hi_byte, mem_data};
                sel_n       = word_idx;
                word_addr_n = word_addr + 11'd2;
                if (word_idx == 2'd2) begin
                    word_idx_n = '0;
                    entry_n    = entry_idx + 16'd1;
                    scanned_n  = scanned_r + 16'd1;
                end else begin
                    word_idx_n = word_idx + 2'd1;
                end
                state_n = last_word ? WAIT_DP : RD_HI;
            end
            WAIT_DP: if (dp_done || done_seen) state_n = FIN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Strobe/address registers hold the values for the state being entered
    always_comb begin
        rd_n    = 1'b0;
        addr_n  = '0;
        start_n = 1'b0;
        done_n  = 1'b0;
        busy_n  = (state_n != IDLE) && (state_n != FIN);
        case (state_n)
            CNT_HI:  begin rd_n = 1'b1; addr_n = BASE_ADDR;           end
            CNT_LO:  begin rd_n = 1'b1; addr_n = BASE_ADDR + 11'd1;   end
            RD_HI:   begin rd_n = 1'b1; addr_n = word_addr_n;         end
            RD_LO:   begin rd_n = 1'b1; addr_n = word_addr_n + 11'd1; end
            PRIME:   start_n = 1'b1;
            FIN:     done_n  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (nrst) begin
            state       <= IDLE;
            hi_byte     <= '0;
            word_addr   <= '0;
            entry_idx   <= '0;
            num_entries <= '0;
            word_idx    <= '0;
            done_seen   <= 1'b0;
            rd_r        <= 1'b0;
            addr_r      <= '0;
            start_r     <= 1'b0;
            valid_r     <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            word_r      <= '0;
            sel_r       <= '0;
            scanned_r   <= '0;
            clamp_r     <= 1'b0;
        end else if (en) begin
            state       <= state_n;
            if (state == CNT_LO || state == RD_LO) hi_byte <= mem_data;
            word_addr   <= word_addr_n;
            entry_idx   <= entry_n;
            num_entries <= num_n;
            word_idx    <= word_idx_n;
            done_seen   <= (state == IDLE || state_n == FIN) ? 1'b0 : (done_seen | dp_done);
            rd_r        <= rd_n;
            addr_r      <= addr_n;
            start_r     <= start_n;
            valid_r     <= valid_n;
            done_r      <= done_n;
            busy_r      <= busy_n;
            word_r      <= word_n;
            sel_r       <= sel_n;
            scanned_r   <= scanned_n;
            clamp_r     <= clamp_n;
        end else begin
            // A stall breaks the read-to-data pipeline, so a half-fetched word is re-read from its HI byte
            done_seen <= done_seen | (dp_done && state != IDLE);
            case (state)
                RD_LO, CAP: begin
                    state  <= RD_HI;
                    rd_r   <= 1'b1;
                    addr_r <= word_addr;
                end
                CNT_LO, CNT_CAP: begin
                    state  <= CNT_HI;
                    rd_r   <= 1'b1;
                    addr_r <= BASE_ADDR;
                end
                default: ;
            endcase
        end
    end

    assign mem_rd    = rd_r & en;
    assign mem_addr  = (rd_r & en) ? addr_r : 11'd0;
    assign dp_start  = start_r & en;
    assign dp_valid  = valid_r & en;
    assign done      = done_r & en;
    assign dp_word   = word_r;
    assign dp_sel    = sel_r;
    assign busy      = busy_r;
    assign scanned   = scanned_r;
    assign clamp_err = clamp_r;

endmodule

// File: doc/neighbor_scan_ctrl.md
NEIGHBOR_SCAN_CTRL -- requirements
Module: neighbor_scan_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  BASE_ADDR, 11'h000, byte address of the neighbor-count word.
  MAX_NEIGHBORS, 32, upper clamp on the scanned entry count.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clock  in  1  single clock; all logic on its rising edge.
  nrst  in  1  reset, synchronous, active-high (1 = reset).
  en  in  1  run enable; 0 = stall.
  start  in  1  scan request pulse.
  mem_rd  out  1  byte read strobe to the 2048x8 neighbor memory.
  mem_addr  out  11  byte address.
  mem_data  in  8  read data, valid the cycle after mem_rd=1.
  dp_start  out  1  one-cycle start pulse to the best-neighbor datapath.
  dp_word  out  16  assembled word {hi byte, lo byte}.
  dp_valid  out  1  dp_word qualifier, one-cycle pulse.
  dp_sel  out  2  word index within entry: 0=neighborID, 1=hops, 2=Q value.
  dp_done  in  1  datapath finished-evaluation pulse.
  busy  out  1  high from accepted start until done.
  done  out  1  one-cycle scan-complete pulse.
  scanned  out  16  number of entries delivered in the last scan.
  clamp_err  out  1  count word exceeded MAX_NEIGHBORS; sticky until the next start.

Function
REQ-003 Memory layout SHALL be: count word at BASE_ADDR (hi byte) and BASE_ADDR+1 (lo byte); entry e, word w at BASE_ADDR+2+2*(3e+w); all address arithmetic modulo 2048.
REQ-004 States SHALL be IDLE, CNT_HI, CNT_LO, CNT_CAP, PRIME, RD_HI, RD_LO, CAP, WAIT_DP, FIN.
REQ-005 In IDLE, start=1 with en=1 SHALL go to CNT_HI, set busy=1, and clear scanned and clamp_err.
REQ-006 Start SHALL be ignored while busy=1.
REQ-007 Word fetch timing SHALL be:
  - RD_HI: mem_rd=1, addr A.
  - RD_LO: mem_rd=1, addr A+1; capture hi byte.
  - CAP: capture lo byte.
  - Each word therefore takes exactly 3 cycles.
REQ-008 The count SHALL be fetched via CNT_HI/CNT_LO/CNT_CAP using the same 3-cycle sequence.
REQ-009 The effective count N SHALL equal min(count, MAX_NEIGHBORS); clamp_err SHALL be set when count > MAX_NEIGHBORS.
REQ-010 After CNT_CAP with N=0, the FSM SHALL go directly to FIN without dp_start or dp_valid.
REQ-011 After CNT_CAP with N>0, the FSM SHALL go to PRIME, assert dp_start for exactly one cycle, then go to RD_HI for entry 0, word 0.
REQ-012 dp_valid SHALL be 1 in the cycle after each CAP, with dp_word and dp_sel registered and stable in that cycle only.
REQ-013 Words SHALL be delivered in order w=0,1,2 per entry and entries in order 0..N-1.
REQ-014 scanned SHALL increment in the cycle dp_valid is asserted with dp_sel=2.
REQ-015 After the last word's CAP, the FSM SHALL enter WAIT_DP and remain there until dp_done=1, then go to FIN.
REQ-016 dp_done arriving before WAIT_DP SHALL be latched and honored on WAIT_DP entry.
REQ-017 FIN SHALL assert done=1 for one cycle, clear busy, and return to IDLE.
REQ-018 When en=0:
  - the FSM SHALL hold state and all registers;
  - mem_rd SHALL be 0;
  - dp_valid, dp_start and done SHALL be 0;
  - a pending output pulse SHALL be emitted once en returns;
  - on en return in RD_LO or CAP (or CNT_LO/CNT_CAP), the current word SHALL restart from its HI state with the same address.
REQ-019 Outputs SHALL be driven from registers; mem_addr SHALL be 0 when mem_rd=0.

Reset
REQ-020 nrst=1 at a clock edge SHALL force IDLE and zero every output: busy, done, dp_start, dp_valid, dp_word, dp_sel, mem_rd, mem_addr, scanned and clamp_err.
REQ-021 Reset asserted mid-scan SHALL abort the scan without emitting done.
REQ-022 Reset SHALL take priority over start and en.

Verification
REQ-023 Nominal scan: BASE=0, count=2, six entry words 0x0005,0x0001,0x1234,0x0007,0x0002,0x0FFF; start pulse ->
  - dp_start 1 cycle;
  - six dp_valid pulses with those words and dp_sel 0,1,2,0,1,2 spaced 3 cycles apart;
  - dp_done pulse -> done 1 cycle, scanned=2, clamp_err=0.
REQ-024 Empty table: count=0 -> no dp_start or dp_valid; done exactly 4 cycles after start acceptance; scanned=0.
REQ-025 Clamp: count=40 with MAX_NEIGHBORS=32 -> clamp_err=1; exactly 96 dp_valid pulses; scanned=32.
REQ-026 Wrap: BASE_ADDR=11'h7FE, count=1 -> count read from 0x7FE/0x7FF; entry words read from 0x000..0x005.
REQ-027 Stall: en=0 for 5 cycles during an RD_LO -> no mem_rd during the stall; word re-read from RD_HI after the stall; dp_word correct; no duplicate dp_valid.
REQ-028 Reset and busy handling:
  - nrst=1 during entry 1 -> all outputs 0 next cycle, no done;
  - a following start runs a full clean scan;
  - a start issued while busy -> ignored.
